// File: rtl/uart_bridge_pkg.sv
// Shared constants, command field layout and FSM states
// for the UART register bridge.
package uart_bridge_pkg;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam int CMD_W_BIT = 7;
  localparam logic [7:0] CMD_RSV_MASK = 8'h70;
  localparam int CMD_ADDR_MSB = 3;
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_ADDR_W =
    CMD_ADDR_MSB - CMD_ADDR_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    GET_DATA,
    SEND,
    WAIT_DONE
  } state_e;

  function automatic logic [CMD_ADDR_W-1:0] cmd_addr(
    input logic [7:0] b
  );
    return b[CMD_ADDR_MSB:CMD_ADDR_LSB];
  endfunction

  function automatic logic cmd_is_wr(
    input logic [7:0] b
  );
    return b[CMD_W_BIT];
  endfunction

  // Reserved bits must be clear and the address in range.
  function automatic logic cmd_ok(
    input logic [7:0] b,
    input int unsigned n
  );
    logic rsv_clear;
    logic in_range;
    rsv_clear = (b & CMD_RSV_MASK) == 8'h00;
    in_range = 32'(cmd_addr(b)) < n;
    return rsv_clear && in_range;
  endfunction

endpackage

// File: rtl/uart_reg_bridge.sv
// Byte command responder: single-byte reads, two-byte
// writes, one response byte per command via the UART tx.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  data_valid,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  busy,
  output logic                  err_overflow
);

  localparam int AW =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [CMD_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  we;
  logic [7:0]            regs_q [NUM_REGS];

  logic                  cmd_good;
  logic                  cmd_wr;

  assign cmd_good = cmd_ok(rx_data, NUM_REGS);
  assign cmd_wr = cmd_is_wr(rx_data);

  // Next-state, response byte, timeout and error flag.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    tx_data_d = tx_data_q;
    cnt_d = '0;
    err_d = err_q;
    we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          unique case (1'b1)
            !cmd_good: begin
              tx_data_d = NAK;
              state_d = SEND;
            end
            cmd_good && cmd_wr: begin
              addr_d = cmd_addr(rx_data);
              state_d = GET_DATA;
            end
            cmd_good && !cmd_wr: begin
              tx_data_d =
                regs_q[cmd_addr(rx_data)][7:0];
              state_d = SEND;
            end
            default: ;
          endcase
        end
      end
      GET_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (data_valid) begin
          we = 1'b1;
          tx_data_d = ACK;
          state_d = SEND;
        end else if (cnt_d == TMO) begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (data_valid) err_d = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (data_valid) err_d = 1'b1;
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, response byte, timeout, sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      tx_data_q <= 8'h00;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      tx_data_q <= tx_data_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Register file, written by the data byte of a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (we) begin
      regs_q[addr_q[AW-1:0]] <= rx_data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign tx_start = (state_q == SEND);
  assign tx_data = tx_data_q;
  assign busy = (state_q != IDLE);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with a short
// timeout so the GET_DATA expiry is reachable.
module tb_uart_reg_bridge;

  localparam int NR = 16;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          data_valid = 1'b0;
  logic          tx_done = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [NR*8-1:0] regs_flat;
  logic          busy;
  logic          err_overflow;

  int n_tests = 0;
  int n_fail = 0;
  logic [NR*8-1:0] exp_regs = '0;
  logic saw_start;

  uart_reg_bridge #(
    .NUM_REGS(NR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .data_valid(data_valid),
    .tx_done(tx_done),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .regs_flat(regs_flat),
    .busy(busy),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [NR*8-1:0] got,
    input logic [NR*8-1:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // From the SEND cycle: check the hold, pulse tx_done.
  task automatic finish_tx(
    input string tag,
    input logic [7:0] exp_data
  );
    @(negedge clk);
    check({tag, "_start_one"}, tx_start, 1'b0);
    check({tag, "_hold"}, tx_data, exp_data);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_start", tx_start, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_overflow, 1'b0);
    check("rst_regs", regs_flat, '0);
    rst = 1'b1;
    @(negedge clk);

    send_byte(8'h03);
    check("rd3_start", tx_start, 1'b1);
    check("rd3_data", tx_data, 8'h00);
    check("rd3_busy", busy, 1'b1);
    finish_tx("rd3", 8'h00);

    send_byte(8'h85);
    check("wr5_busy", busy, 1'b1);
    check("wr5_nostart", tx_start, 1'b0);
    send_byte(8'hA5);
    exp_regs[47:40] = 8'hA5;
    check("wr5_reg", regs_flat[47:40], 8'hA5);
    check("wr5_ack_start", tx_start, 1'b1);
    check("wr5_ack", tx_data, 8'h06);
    finish_tx("wr5", 8'h06);
    send_byte(8'h05);
    check("rd5_data", tx_data, 8'hA5);
    finish_tx("rd5", 8'hA5);

    send_byte(8'h93);
    check("nak_start", tx_start, 1'b1);
    check("nak_data", tx_data, 8'h15);
    check("nak_regs", regs_flat, exp_regs);
    finish_tx("nak", 8'h15);
    send_byte(8'h05);
    check("after_nak", tx_data, 8'hA5);
    finish_tx("after_nak", 8'hA5);

    saw_start = 1'b0;
    send_byte(8'h82);
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      if (tx_start) saw_start = 1'b1;
    end
    check("tmo_busy_49", busy, 1'b1);
    @(negedge clk);
    if (tx_start) saw_start = 1'b1;
    check("tmo_idle_50", busy, 1'b0);
    check("tmo_nostart", saw_start, 1'b0);
    check("tmo_regs", regs_flat, exp_regs);
    send_byte(8'h02);
    check("tmo_rd2_start", tx_start, 1'b1);
    check("tmo_rd2_data", tx_data, 8'h00);
    finish_tx("tmo_rd2", 8'h00);

    send_byte(8'h84);
    for (int i = 1; i < TMO; i++) @(negedge clk);
    send_byte(8'h3C);
    exp_regs[39:32] = 8'h3C;
    check("term_start", tx_start, 1'b1);
    check("term_ack", tx_data, 8'h06);
    check("term_regs", regs_flat, exp_regs);
    finish_tx("term", 8'h06);

    send_byte(8'h05);
    @(negedge clk);
    rx_data = 8'h01;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("ovf_err", err_overflow, 1'b1);
    check("ovf_busy", busy, 1'b1);
    check("ovf_nostart", tx_start, 1'b0);
    data_valid = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    tx_done = 1'b0;
    check("ovf_co_idle", busy, 1'b0);
    check("ovf_co_err", err_overflow, 1'b1);
    check("ovf_co_regs", regs_flat, exp_regs);
    send_byte(8'h04);
    check("ovf_rd4", tx_data, 8'h3C);
    finish_tx("ovf_rd4", 8'h3C);
    check("ovf_sticky", err_overflow, 1'b1);

    send_byte(8'h81);
    send_byte(8'h77);
    exp_regs[15:8] = 8'h77;
    check("wr1_regs", regs_flat, exp_regs);
    @(negedge clk);
    check("wr1_wait", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_start", tx_start, 1'b0);
    check("arst_data", tx_data, 8'h00);
    check("arst_err", err_overflow, 1'b0);
    check("arst_regs", regs_flat, '0);
    exp_regs = '0;
    @(negedge clk);
    rst = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("arst_done_ign", busy, 1'b0);
    send_byte(8'h01);
    check("arst_rd1_start", tx_start, 1'b1);
    check("arst_rd1", tx_data, 8'h00);
    finish_tx("arst_rd1", 8'h00);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
